scanline_fetch: RTL

- Upstream feeder for the per-line pixel buffer.
- On each line pulse it decides whether a new source row is needed, given vertical scale.
- When a row is needed, it reads that row from video memory over a req/ack handshake and streams the words into the buffer's write port (enable_input/data_in).
- Lines repeated by vertical scaling issue no writes, so the buffer keeps the previous row.

---
 rtl/scanline_fetch.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/scanline_fetch.sv
// rtl/scanline_fetch.sv - per-line row fetcher feeding the line buffer write port
// Decides per line pulse whether a new source row is needed and streams it from video memory.
module scanline_fetch #(
    parameter int DATA_WIDTH  = 8,
    parameter int LENGTH      = 640,
    parameter int ADDR_WIDTH  = 16,
    parameter int SCALE_WIDTH = 6
) (
    input  logic                           clk_pixel,
    input  logic                           reset,
    input  logic                           frame,
    input  logic                           line,
    input  logic                           active_line,
    input  logic [SCALE_WIDTH-1:0]         scale,
    input  logic [ADDR_WIDTH-1:0]          base_addr,
    input  logic [ADDR_WIDTH-1:0]          stride,
    input  logic [$clog2(LENGTH+1)-1:0]    width,
    output logic                           mem_req,
    output logic [ADDR_WIDTH-1:0]          mem_addr,
    input  logic                           mem_ack,
    input  logic [DATA_WIDTH-1:0]          mem_data,
    output logic                           lb_enable_input,
    output logic [DATA_WIDTH-1:0]          lb_data_in,
    output logic                           busy,
    output logic                           overrun
);
    localparam int CW = $clog2(LENGTH + 1);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    state_t                 state_q;
    logic [SCALE_WIDTH-1:0] vcount_q;
    logic [ADDR_WIDTH-1:0]  row_addr_q;
    logic [ADDR_WIDTH-1:0]  fetch_addr_q;
    logic [ADDR_WIDTH-1:0]  pend_addr_q;
    logic [CW-1:0]          remaining_q;
    logic [CW-1:0]          pend_rem_q;
    logic                   pend_q;
    logic                   wr_q;
    logic                   overrun_q;
    logic [DATA_WIDTH-1:0]  data_q;

    // Frame is folded in first so a coincident line sees the new frame's row/vcount.
    logic [SCALE_WIDTH-1:0] vcount_cur, vcount_d, eff_scale_m1;
    logic [ADDR_WIDTH-1:0]  row_cur, row_addr_d;
    logic [CW-1:0]          width_clamped;
    logic                   new_row, start_fetch;

    always_comb begin
        row_cur       = frame ? base_addr : row_addr_q;
        vcount_cur    = frame ? '0 : vcount_q;
        eff_scale_m1  = (scale == '0) ? '0 : SCALE_WIDTH'(scale - 1'b1);
        width_clamped = (width > CW'(LENGTH)) ? CW'(LENGTH) : width;
        new_row       = line && active_line && (vcount_cur == '0);
        start_fetch   = new_row && (width_clamped != '0);
        vcount_d      = vcount_cur;
        row_addr_d    = row_cur;
        if (line && active_line) begin
            vcount_d = (vcount_cur >= eff_scale_m1) ? '0 : SCALE_WIDTH'(vcount_cur + 1'b1);
            if (new_row) begin
                row_addr_d = row_cur + stride;
            end
        end
    end

    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            state_q      <= IDLE;
            vcount_q     <= '0;
            row_addr_q   <= '0;
            fetch_addr_q <= '0;
            pend_addr_q  <= '0;
            remaining_q  <= '0;
            pend_rem_q   <= '0;
            pend_q       <= 1'b0;
            wr_q         <= 1'b0;
            overrun_q    <= 1'b0;
            data_q       <= '0;
        end else begin
            vcount_q   <= vcount_d;
            row_addr_q <= row_addr_d;
            wr_q       <= 1'b0;
            overrun_q  <= frame ? 1'b0 : overrun_q;
            case (state_q)
                IDLE: begin
                    if (start_fetch) begin
                        fetch_addr_q <= row_cur;
                        remaining_q  <= width_clamped;
                        state_q      <= FETCH;
                    end
                end
                FETCH: begin
                    if (line) begin
                        overrun_q <= 1'b1;
                        if (mem_ack) begin
                            // The returning word belongs to the old row; drop it and restart now.
                            if (start_fetch) begin
                                fetch_addr_q <= row_cur;
                                remaining_q  <= width_clamped;
                            end else begin
                                state_q <= IDLE;
                            end
                        end else begin
                            pend_q      <= start_fetch;
                            pend_addr_q <= row_cur;
                            pend_rem_q  <= width_clamped;
                            state_q     <= DRAIN;
                        end
                    end else if (mem_ack) begin
                        wr_q         <= 1'b1;
                        data_q       <= mem_data;
                        fetch_addr_q <= fetch_addr_q + 1'b1;
                        remaining_q  <= remaining_q - 1'b1;
                        if (remaining_q == CW'(1)) begin
                            state_q <= IDLE;
                        end
                    end
                end
                DRAIN: begin
                    if (line) begin
                        overrun_q <= 1'b1;
                    end
                    if (mem_ack) begin
                        if (line ? start_fetch : pend_q) begin
                            fetch_addr_q <= line ? row_cur : pend_addr_q;
                            remaining_q  <= line ? width_clamped : pend_rem_q;
                            state_q      <= FETCH;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else if (line) begin
                        pend_q      <= start_fetch;
                        pend_addr_q <= row_cur;
                        pend_rem_q  <= width_clamped;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // The buffer clears its write pointer on line, so a word landing then would go astray.
    assign lb_enable_input = wr_q && !line;
    assign lb_data_in      = data_q;
    assign mem_req         = (state_q != IDLE);
    assign mem_addr        = fetch_addr_q;
    assign busy            = (state_q != IDLE);
    assign overrun         = overrun_q;
endmodule
